// File: rtl/serdes_pattern_gen.sv
// serdes_pattern_gen
// Test-data source for the LVDS serializer path. Writes framed bursts into
// the serializer input FIFO: TRAIN_LEN training words, then BURST_LEN payload
// words from a selectable deterministic generator, then GAP_LEN idle cycles.
// Generators free-run across bursts so the far-end checker stays in lock.
//
// Ports:
//   clk        system clock (clk_ms from the clock/reset generator)
//   res_n      synchronous active-low reset
//   en         run enable (level); a started burst always completes
//   mode       payload select: 0 incr, 1 PRBS-8, 2 walking-one, 3 55/AA
//   fifo_full  FIFO full flag, stalls TRAIN/BURST
//   data       registered FIFO write data, held until accepted
//   wr_en      FIFO write strobe (combinational from fifo_full)
//   busy       high whenever the block is not IDLE
//   burst_cnt  saturating count of completed bursts
module serdes_pattern_gen #(
    parameter int                DATA_W     = 8,
    parameter int                TRAIN_LEN  = 4,
    parameter logic [DATA_W-1:0] TRAIN_WORD = 8'hA5,
    parameter int                BURST_LEN  = 64,
    parameter int                GAP_LEN    = 4,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] data,
    output logic              wr_en,
    output logic              busy,
    output logic [CNT_W-1:0]  burst_cnt
);

    // The word counter only ever reaches LEN-1 of the longest phase.
    localparam int MAX_LEN = (TRAIN_LEN > BURST_LEN)
                           ? ((TRAIN_LEN > GAP_LEN) ? TRAIN_LEN : GAP_LEN)
                           : ((BURST_LEN > GAP_LEN) ? BURST_LEN : GAP_LEN);
    localparam int WC_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRAIN = 2'd1,
        S_BURST = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Galois right-shift PRBS-8; a non-zero seed never reaches zero.
    function automatic logic [DATA_W-1:0] prbs_step(input logic [DATA_W-1:0] s);
        return (s >> 1) ^ (s[0] ? DATA_W'(8'hB8) : '0);
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic [WC_W-1:0]     r_wcnt;
    logic [1:0]          r_mode_q;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_burst_cnt;
    logic [DATA_W-1:0]   r_inc;
    logic [DATA_W-1:0]   r_lfsr;
    logic [DATA_W-1:0]   r_walk;
    logic [DATA_W-1:0]   r_alt;

    logic                w_pending;
    logic                w_accept;
    logic                w_start;
    logic                w_train_done;
    logic                w_burst_done;
    logic [DATA_W-1:0]   w_inc_nxt;
    logic [DATA_W-1:0]   w_lfsr_nxt;
    logic [DATA_W-1:0]   w_walk_nxt;
    logic [DATA_W-1:0]   w_alt_nxt;
    logic [DATA_W-1:0]   w_pat_cur;
    logic [DATA_W-1:0]   w_pat_nxt;

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---- next-state / handshake decode ----
    always_comb begin
        w_next       = r_state;
        w_pending    = 1'b0;
        w_start      = 1'b0;
        w_train_done = 1'b0;
        w_burst_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_next  = S_TRAIN;
                    w_start = 1'b1;
                end
            end
            S_TRAIN: begin
                w_pending = 1'b1;
                if (!fifo_full && r_wcnt == WC_W'(TRAIN_LEN - 1)) begin
                    w_train_done = 1'b1;
                    w_next       = S_BURST;
                end
            end
            S_BURST: begin
                w_pending = 1'b1;
                if (!fifo_full && r_wcnt == WC_W'(BURST_LEN - 1)) begin
                    w_burst_done = 1'b1;
                    w_next       = S_GAP;
                end
            end
            S_GAP: begin
                if (r_wcnt == WC_W'(GAP_LEN - 1)) begin
                    w_next  = en ? S_TRAIN : S_IDLE;
                    w_start = en;
                end
            end
            default: w_next = S_IDLE;
        endcase
        w_accept = w_pending & ~fifo_full;
    end

    // ---- pattern generator select ----
    always_comb begin
        w_inc_nxt  = r_inc + DATA_W'(1);
        w_lfsr_nxt = prbs_step(r_lfsr);
        w_walk_nxt = {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
        w_alt_nxt  = ~r_alt;
        case (r_mode_q)
            2'd0: begin w_pat_cur = r_inc;  w_pat_nxt = w_inc_nxt;  end
            2'd1: begin w_pat_cur = r_lfsr; w_pat_nxt = w_lfsr_nxt; end
            2'd2: begin w_pat_cur = r_walk; w_pat_nxt = w_walk_nxt; end
            default: begin w_pat_cur = r_alt; w_pat_nxt = w_alt_nxt; end
        endcase
    end

    // ---- datapath / counters ----
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_wcnt      <= '0;
            r_mode_q    <= 2'd0;
            r_data      <= '0;
            r_burst_cnt <= '0;
            r_inc       <= DATA_W'(8'h00);
            r_lfsr      <= DATA_W'(8'h01);
            r_walk      <= DATA_W'(8'h01);
            r_alt       <= DATA_W'(8'h55);
        end else begin
            // Counts accepted writes in TRAIN/BURST, elapsed cycles in GAP.
            if (w_next != r_state) begin
                r_wcnt <= '0;
            end else if (w_accept || r_state == S_GAP) begin
                r_wcnt <= r_wcnt + WC_W'(1);
            end

            if (w_start) begin
                r_mode_q <= mode;
                r_data   <= TRAIN_WORD;
            end

            // Generators hold the next unsent word, so the first payload
            // word is simply the current value of the selected one.
            if (w_train_done) begin
                r_data <= w_pat_cur;
            end

            if (r_state == S_BURST && w_accept) begin
                case (r_mode_q)
                    2'd0:    r_inc  <= w_inc_nxt;
                    2'd1:    r_lfsr <= w_lfsr_nxt;
                    2'd2:    r_walk <= w_walk_nxt;
                    default: r_alt  <= w_alt_nxt;
                endcase
                if (w_burst_done) begin
                    r_burst_cnt <= sat_inc(r_burst_cnt);
                end else begin
                    r_data <= w_pat_nxt;
                end
            end
        end
    end

    assign data      = r_data;
    assign wr_en     = w_accept;
    assign busy      = (r_state != S_IDLE);
    assign burst_cnt = r_burst_cnt;

endmodule

// File: tb/tb_serdes_pattern_gen.sv
module tb_serdes_pattern_gen;

    logic        clk = 1'b0;
    logic        res_n, en, fifo_full;
    logic [1:0]  mode;
    logic [7:0]  data;
    logic        wr_en, busy;
    logic [15:0] burst_cnt;

    logic        res_n2, en2, fifo_full2;
    logic [1:0]  mode2;
    logic [7:0]  data2;
    logic        wr_en2, busy2;
    logic [1:0]  burst_cnt2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    serdes_pattern_gen #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .res_n(res_n), .en(en), .mode(mode), .fifo_full(fifo_full),
        .data(data), .wr_en(wr_en), .busy(busy), .burst_cnt(burst_cnt)
    );

    serdes_pattern_gen #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .res_n(res_n2), .en(en2), .mode(mode2), .fifo_full(fifo_full2),
        .data(data2), .wr_en(wr_en2), .busy(busy2), .burst_cnt(burst_cnt2)
    );

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic        full;
        logic        exp_wr;
        logic        exp_busy;
        logic        chk_data;
        logic [7:0]  exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 81;
    vec_t vec [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive DUT1 inputs just after the falling edge, then settle before checking.
    task automatic step(input logic rn, input logic e, input logic [1:0] m, input logic f);
        @(negedge clk);
        res_n = rn; en = e; mode = m; fifo_full = f;
        #1;
    endtask

    task automatic step2(input logic rn, input logic e, input logic [1:0] m, input logic f);
        @(negedge clk);
        res_n2 = rn; en2 = e; mode2 = m; fifo_full2 = f;
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        int          widx, npay, nwr, bad, zeros, reps, trbad;
        logic [7:0]  pay [255];
        logic        seen [256];
        logic [7:0]  s;
        logic [7:0]  exp_alt;

        res_n = 1'b0; en = 1'b0; mode = 2'd0; fifo_full = 1'b0;
        res_n2 = 1'b0; en2 = 1'b0; mode2 = 2'd0; fifo_full2 = 1'b0;

        // Vector table for the basic increment run (cycle 0 = en sampled in IDLE).
        for (int k = 0; k < NV; k++) begin
            vec[k].en = 1'b1; vec[k].mode = 2'd0; vec[k].full = 1'b0;
            if (k == 0) begin
                vec[k].exp_wr = 0; vec[k].exp_busy = 0; vec[k].chk_data = 1;
                vec[k].exp_data = 8'h00; vec[k].exp_cnt = 16'd0;
            end else if (k <= 4) begin
                vec[k].exp_wr = 1; vec[k].exp_busy = 1; vec[k].chk_data = 1;
                vec[k].exp_data = 8'hA5; vec[k].exp_cnt = 16'd0;
            end else if (k <= 68) begin
                vec[k].exp_wr = 1; vec[k].exp_busy = 1; vec[k].chk_data = 1;
                vec[k].exp_data = 8'(k - 5); vec[k].exp_cnt = 16'd0;
            end else if (k <= 72) begin
                vec[k].exp_wr = 0; vec[k].exp_busy = 1; vec[k].chk_data = 0;
                vec[k].exp_data = 8'h00; vec[k].exp_cnt = 16'd1;
            end else if (k <= 76) begin
                vec[k].exp_wr = 1; vec[k].exp_busy = 1; vec[k].chk_data = 1;
                vec[k].exp_data = 8'hA5; vec[k].exp_cnt = 16'd1;
            end else begin
                vec[k].exp_wr = 1; vec[k].exp_busy = 1; vec[k].chk_data = 1;
                vec[k].exp_data = 8'(8'h40 + k - 77); vec[k].exp_cnt = 16'd1;
            end
        end

        // Reset state
        do_reset();
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_wr", 32'(wr_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(burst_cnt), 32'h0);

        // Increment burst, gap, second burst start
        for (int k = 0; k < NV; k++) begin
            step(1'b1, vec[k].en, vec[k].mode, vec[k].full);
            chk($sformatf("vec%0d_wr", k), 32'(wr_en), 32'(vec[k].exp_wr));
            chk($sformatf("vec%0d_busy", k), 32'(busy), 32'(vec[k].exp_busy));
            chk($sformatf("vec%0d_cnt", k), 32'(burst_cnt), 32'(vec[k].exp_cnt));
            if (vec[k].chk_data)
                chk($sformatf("vec%0d_data", k), 32'(data), 32'(vec[k].exp_data));
        end

        // PRBS-8 over 255 payload words spanning several bursts
        do_reset();
        widx = 0; npay = 0; trbad = 0;
        for (int c = 0; c < 1000 && npay < 255; c++) begin
            step(1'b1, 1'b1, 2'd1, 1'b0);
            if (wr_en) begin
                if ((widx % 68) < 4) begin
                    if (data !== 8'hA5) trbad++;
                end else begin
                    pay[npay] = data;
                    npay++;
                end
                widx++;
            end
        end
        chk("prbs_count", 32'(npay), 32'd255);
        chk("prbs_train", 32'(trbad), 32'd0);
        chk("prbs_w0", 32'(pay[0]), 32'h01);
        chk("prbs_w1", 32'(pay[1]), 32'hB8);
        chk("prbs_w2", 32'(pay[2]), 32'h5C);
        chk("prbs_w3", 32'(pay[3]), 32'h2E);
        chk("prbs_w4", 32'(pay[4]), 32'h17);
        chk("prbs_w5", 32'(pay[5]), 32'hB3);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        s = 8'h01; bad = 0; zeros = 0; reps = 0;
        for (int i = 0; i < 255; i++) begin
            if (pay[i] !== s) bad++;
            if (pay[i] == 8'h00) zeros++;
            if (seen[pay[i]]) reps++;
            seen[pay[i]] = 1'b1;
            s = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
        end
        chk("prbs_seq", 32'(bad), 32'd0);
        chk("prbs_zero", 32'(zeros), 32'd0);
        chk("prbs_repeat", 32'(reps), 32'd0);

        // FIFO-full stall of 5 cycles at payload word 0x0A; en dropped mid-burst
        do_reset();
        nwr = 0;
        for (int c = 0; c <= 90; c++) begin
            step(1'b1, (c <= 21), 2'd0, (c >= 15 && c <= 19));
            if (c >= 15 && c <= 19) begin
                chk($sformatf("stall%0d_wr", c), 32'(wr_en), 32'd0);
                chk($sformatf("stall%0d_data", c), 32'(data), 32'h0A);
            end
            if (c == 20) begin
                chk("resume_wr", 32'(wr_en), 32'd1);
                chk("resume_data0", 32'(data), 32'h0A);
            end
            if (c == 21) chk("resume_data1", 32'(data), 32'h0B);
            if (c == 73) chk("stall_last", 32'(data), 32'h3F);
            if (c == 74) chk("stall_gap_wr", 32'(wr_en), 32'd0);
            if (c == 78) chk("stall_idle", 32'(busy), 32'd0);
            if (c >= 5 && wr_en) nwr++;
        end
        chk("stall_total", 32'(nwr), 32'd64);

        // en dropped at payload word 20 and mode changed to walking-one
        do_reset();
        bad = 0;
        for (int c = 0; c <= 73; c++) begin
            step(1'b1, (c < 25), (c < 25) ? 2'd0 : 2'd2, 1'b0);
            if (c >= 25 && c <= 68 && (wr_en !== 1'b1 || data !== 8'(c - 5))) bad++;
            if (c >= 69 && c <= 72) begin
                chk($sformatf("drop_gap%0d_wr", c), 32'(wr_en), 32'd0);
                chk($sformatf("drop_gap%0d_busy", c), 32'(busy), 32'd1);
            end
        end
        chk("drop_incr_tail", 32'(bad), 32'd0);
        chk("drop_idle_busy", 32'(busy), 32'd0);
        chk("drop_idle_cnt", 32'(burst_cnt), 32'd1);
        step(1'b1, 1'b1, 2'd2, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 1'b1, 2'd2, 1'b0);
            chk($sformatf("walk_train%0d", c), 32'(data), 32'hA5);
        end
        for (int k = 0; k < 30; k++) begin
            step(1'b1, 1'b1, 2'd2, 1'b0);
            chk($sformatf("walk%0d", k), 32'(data), 32'(8'h01 << (k % 8)));
        end

        // Reset pulse at payload word 30 of the walking-one burst
        step(1'b0, 1'b1, 2'd2, 1'b0);
        chk("rstmid_before", 32'(data), 32'h40);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        chk("rstmid_wr", 32'(wr_en), 32'd0);
        chk("rstmid_data", 32'(data), 32'h00);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cnt", 32'(burst_cnt), 32'd0);
        step(1'b1, 1'b1, 2'd0, 1'b0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 2'd0, 1'b0);
            chk($sformatf("restart%0d", k), 32'(data), 32'(k));
        end

        // Alternation pattern with a 2-bit burst counter, 5 bursts
        step2(1'b0, 1'b0, 2'd0, 1'b0);
        step2(1'b0, 1'b0, 2'd0, 1'b0);
        chk("sat_rst_cnt", 32'(burst_cnt2), 32'd0);
        bad = 0;
        exp_alt = 8'h55;
        for (int c = 0; c <= 360; c++) begin
            step2(1'b1, 1'b1, 2'd3, 1'b0);
            if (c >= 1 && ((c - 1) % 72) >= 4 && ((c - 1) % 72) <= 67) begin
                if (wr_en2 !== 1'b1 || data2 !== exp_alt) bad++;
                exp_alt = ~exp_alt;
            end
            for (int b = 0; b < 5; b++) begin
                if (c == 68 + 72 * b)
                    chk($sformatf("sat_pre%0d", b), 32'(burst_cnt2), (b < 3) ? b : 3);
                if (c == 69 + 72 * b)
                    chk($sformatf("sat_post%0d", b), 32'(burst_cnt2), (b + 1 < 3) ? b + 1 : 3);
            end
        end
        chk("alt_seq", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
